ltc2333_acq_sequencer: RTL and testbench

LTC2333_ACQ_SEQUENCER -- requirements
Module: ltc2333_acq_sequencer

---
 rtl/ltc2333_pkg.sv | 32 +++
 rtl/ltc2333_chan_select.sv | 25 ++
 rtl/ltc2333_acq_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ltc2333_acq_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2333_pkg.sv
// Shared types for the LTC2333 acquisition sequencer: FSM states and the
// conversion-configuration word layout presented to the write engine.
package ltc2333_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      ISSUE     = 3'd2,
      WAIT_DONE = 3'd3,
      NEXT_CH   = 3'd4
   } acq_state_e;

   // conv_cfg bit layout, MSB first: {valid, channel[2:0], range[2:0], mode}
   typedef struct packed {
      logic       valid;
      logic [2:0] ch;
      logic [2:0] rng;
      logic       mode;
   } conv_cfg_t;

   function automatic conv_cfg_t make_cfg(input logic [2:0] ch,
                                          input logic [2:0] rng,
                                          input logic       mode);
      conv_cfg_t c;
      c.valid = 1'b1;
      c.ch    = ch;
      c.rng   = rng;
      c.mode  = mode;
      return c;
   endfunction

endpackage

// File: rtl/ltc2333_chan_select.sv
// Priority encoder: lowest set bit of mask_i at index >= from_i.
// from_i == 8 means "nothing left" and always reports found_o = 0.
module ltc2333_chan_select (
   input  logic [7:0] mask_i,
   input  logic [3:0] from_i,
   output logic       found_o,
   output logic [2:0] ch_o
);

   logic [7:0] masked;

   always_comb begin
      masked  = mask_i & ~((8'd1 << from_i) - 8'd1);
      found_o = 1'b0;
      ch_o    = '0;
      // scan downwards so the lowest eligible channel is written last
      for (int unsigned j = 0; j < 8; j++) begin
         if (masked[3'(7 - j)]) begin
            found_o = 1'b1;
            ch_o    = 3'(7 - j);
         end
      end
   end

endmodule

// File: rtl/ltc2333_acq_sequencer.sv
// Periodic multi-channel conversion sequencer for the LTC2333: issues one
// conversion request per active channel each sample period, tracks overruns.
module ltc2333_acq_sequencer
   import ltc2333_pkg::*;
#(
   parameter int unsigned CLOCK_PERIOD = 20,
   parameter int unsigned PERIOD_W     = 32,
   parameter int unsigned NREAD_W      = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic [PERIOD_W-1:0] sample_period,
   input  logic [NREAD_W-1:0]  n_reads,
   input  logic [7:0]          active_channels,
   input  logic [2:0]          range,
   input  logic                mode,
   output logic                conv_req,
   output logic [7:0]          conv_cfg,
   input  logic                conv_ack,
   input  logic                conv_done,
   output logic                read_in_progress,
   output logic                timetrig,
   output logic [15:0]         overrun_count,
   output logic                cfg_error
);

   // CLOCK_PERIOD documents the clk period in ns; nothing depends on it.
   if (CLOCK_PERIOD == 0) begin : g_clock_period_doc
   end

   acq_state_e          state_q;
   logic [PERIOD_W-1:0] per_q, cnt_q, per_in;
   logic [NREAD_W-1:0]  nrd_q, swp_q, swp_inc;
   logic [7:0]          chmask_q;
   logic [2:0]          rng_q;
   logic                mode_q;
   logic [2:0]          ch_q;
   logic                stop_pend_q;
   logic                conv_req_q;
   conv_cfg_t           cfg_q;
   logic                timetrig_q, cfg_err_q, rip_q;
   logic [15:0]         ovr_q;
   logic                tick;
   logic [3:0]          sel_from;
   logic                sel_found;
   logic [2:0]          sel_ch;

   always_comb begin
      per_in   = (sample_period == '0) ? PERIOD_W'(1) : sample_period;
      tick     = (state_q != IDLE) && (cnt_q == per_q - PERIOD_W'(1));
      sel_from = (state_q == WAIT_TICK) ? 4'd0 : ({1'b0, ch_q} + 4'd1);
      swp_inc  = swp_q + NREAD_W'(1);
   end

   ltc2333_chan_select u_chan_select (
      .mask_i  (chmask_q),
      .from_i  (sel_from),
      .found_o (sel_found),
      .ch_o    (sel_ch)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         per_q       <= '0;
         cnt_q       <= '0;
         nrd_q       <= '0;
         swp_q       <= '0;
         chmask_q    <= '0;
         rng_q       <= '0;
         mode_q      <= 1'b0;
         ch_q        <= '0;
         stop_pend_q <= 1'b0;
         conv_req_q  <= 1'b0;
         cfg_q       <= '0;
         timetrig_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
         rip_q       <= 1'b0;
         ovr_q       <= '0;
      end else begin
         timetrig_q <= 1'b0;
         cfg_err_q  <= 1'b0;

         // Period timer runs independently of the sweep state once started.
         if (state_q != IDLE)
            cnt_q <= tick ? '0 : cnt_q + PERIOD_W'(1);
         if (tick && state_q != WAIT_TICK && ovr_q != '1)
            ovr_q <= ovr_q + 16'd1;

         case (state_q)
            IDLE: begin
               if (start && !stop) begin
                  if (active_channels == '0) begin
                     cfg_err_q <= 1'b1;
                  end else begin
                     per_q       <= per_in;
                     cnt_q       <= per_in - PERIOD_W'(1);
                     nrd_q       <= n_reads;
                     chmask_q    <= active_channels;
                     rng_q       <= range;
                     mode_q      <= mode;
                     swp_q       <= '0;
                     ovr_q       <= '0;
                     stop_pend_q <= 1'b0;
                     state_q     <= WAIT_TICK;
                     rip_q       <= 1'b1;
                  end
               end
            end
            WAIT_TICK: begin
               if (stop) begin
                  state_q <= IDLE;
                  rip_q   <= 1'b0;
               end else if (tick) begin
                  timetrig_q <= 1'b1;
                  ch_q       <= sel_ch;
                  state_q    <= ISSUE;
               end
            end
            ISSUE: begin
               if (stop)
                  stop_pend_q <= 1'b1;
               // First ISSUE cycle loads the request; it then holds until acked.
               if (!conv_req_q) begin
                  conv_req_q <= 1'b1;
                  cfg_q      <= make_cfg(ch_q, rng_q, mode_q);
               end else if (conv_ack) begin
                  conv_req_q <= 1'b0;
                  cfg_q      <= '0;
                  state_q    <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (stop)
                  stop_pend_q <= 1'b1;
               if (conv_done) begin
                  if (stop || stop_pend_q) begin
                     state_q     <= IDLE;
                     rip_q       <= 1'b0;
                     stop_pend_q <= 1'b0;
                  end else begin
                     state_q <= NEXT_CH;
                  end
               end
            end
            NEXT_CH: begin
               if (stop || stop_pend_q) begin
                  state_q     <= IDLE;
                  rip_q       <= 1'b0;
                  stop_pend_q <= 1'b0;
               end else if (sel_found) begin
                  ch_q    <= sel_ch;
                  state_q <= ISSUE;
               end else begin
                  swp_q <= swp_inc;
                  if (nrd_q != '0 && swp_inc == nrd_q) begin
                     state_q <= IDLE;
                     rip_q   <= 1'b0;
                  end else begin
                     state_q <= WAIT_TICK;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               rip_q   <= 1'b0;
            end
         endcase
      end
   end

   assign conv_req         = conv_req_q;
   assign conv_cfg         = cfg_q;
   assign timetrig         = timetrig_q;
   assign cfg_error        = cfg_err_q;
   assign read_in_progress = rip_q;
   assign overrun_count    = ovr_q;

endmodule

// File: tb/tb_ltc2333_acq_sequencer.sv
// Self-checking bench: table and random sweeps against an expected channel
// list and a tick-timeline overrun scoreboard, plus multi-cycle corner cases.
module tb_ltc2333_acq_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, stop;
   logic [31:0] sample_period;
   logic [15:0] n_reads;
   logic [7:0]  active_channels;
   logic [2:0]  range;
   logic        mode;
   logic        conv_req, conv_ack, conv_done;
   logic [7:0]  conv_cfg;
   logic        read_in_progress, timetrig, cfg_error;
   logic [15:0] overrun_count;

   always #5 clk = ~clk;

   ltc2333_acq_sequencer #(.CLOCK_PERIOD(10), .PERIOD_W(32), .NREAD_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .sample_period(sample_period), .n_reads(n_reads),
      .active_channels(active_channels), .range(range), .mode(mode),
      .conv_req(conv_req), .conv_cfg(conv_cfg), .conv_ack(conv_ack),
      .conv_done(conv_done), .read_in_progress(read_in_progress),
      .timetrig(timetrig), .overrun_count(overrun_count), .cfg_error(cfg_error)
   );

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // ---------------- write-engine responder ----------------
   int unsigned ack_dly = 0, done_dly = 0, done_cnt = 0, last_done_cyc = 0;
   bit          resp_en = 1'b0;
   logic [7:0]  got_q[$];
   logic [7:0]  c0;

   initial begin
      conv_ack  = 1'b0;
      conv_done = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && conv_req === 1'b1 && reset === 1'b0) begin
            c0 = conv_cfg;
            for (int unsigned i = 0; i < ack_dly; i++) begin
               @(negedge clk);
               chk("req_hold", conv_req, 1);
               chk("cfg_hold", conv_cfg, c0);
            end
            conv_ack = 1'b1;
            got_q.push_back(c0);
            @(negedge clk);
            conv_ack = 1'b0;
            chk("req_drop", conv_req, 0);
            repeat (done_dly) @(negedge clk);
            conv_done     = 1'b1;
            last_done_cyc = cyc;
            done_cnt++;
            @(negedge clk);
            conv_done = 1'b0;
         end
      end
   end

   // ---------------- tick timeline scoreboard ----------------
   bit          mon_on = 1'b0;
   int unsigned mon_start = 0, mon_p = 1, tick_seen = 0, trig_cnt = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (timetrig === 1'b1) trig_cnt++;
            if (read_in_progress === 1'b1 && cyc > mon_start &&
                ((cyc - mon_start - 1) % mon_p) == 0)
               tick_seen++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic do_start(input int unsigned per, input int unsigned nr,
                           input logic [7:0] msk, input logic [2:0] rg, input logic md);
      sample_period   = per;
      n_reads         = 16'(nr);
      active_channels = msk;
      range           = rg;
      mode            = md;
      start           = 1'b1;
      mon_start       = cyc;
      mon_p           = (per == 0) ? 1 : per;
      tick_seen       = 0;
      trig_cnt        = 0;
      mon_on          = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int unsigned lim, output bit ok);
      ok = 1'b0;
      for (int unsigned i = 0; i < lim; i++) begin
         if (read_in_progress === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   function automatic logic [2:0] lowest(input logic [7:0] m);
      logic [2:0] r = '0;
      for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
      return r;
   endfunction

   typedef struct {
      int unsigned period;
      int unsigned nreads;
      logic [7:0]  mask;
      logic [2:0]  rng;
      logic        md;
      int unsigned ackd;
      int unsigned doned;
      int unsigned exp_conv;
      bit          need_ovr;
   } vec_t;

   function automatic vec_t mk(input int unsigned p, input int unsigned n, input logic [7:0] m,
                               input logic [2:0] r, input logic d, input int unsigned a,
                               input int unsigned dn, input int unsigned ec, input bit no);
      vec_t v;
      v.period = p; v.nreads = n; v.mask = m; v.rng = r; v.md = d;
      v.ackd = a; v.doned = dn; v.exp_conv = ec; v.need_ovr = no;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      logic [7:0] exp_q[$];
      bit ok;
      got_q.delete();
      ack_dly  = v.ackd;
      done_dly = v.doned;
      resp_en  = 1'b1;
      for (int unsigned s = 0; s < v.nreads; s++)
         for (int unsigned ch = 0; ch < 8; ch++)
            if (v.mask[ch]) exp_q.push_back({1'b1, 3'(ch), v.rng, v.md});
      do_start(v.period, v.nreads, v.mask, v.rng, v.md);
      wait_idle(20000, ok);
      mon_on = 1'b0;
      chk("sweep_done", ok, 1);
      chk("n_conv", got_q.size(), v.exp_conv);
      chk("n_conv_model", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk("cfg_seq", got_q[i], exp_q[i]);
      chk("timetrig_cnt", trig_cnt, v.nreads);
      chk("overrun", overrun_count, tick_seen - trig_cnt);
      if (v.need_ovr) chk("overrun_nonzero", overrun_count != 16'd0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic lat_test(input logic [7:0] msk);
      bit ok;
      ack_dly = 0; done_dly = 1; resp_en = 1'b1;
      do_start(100, 1, msk, 3'b101, 1'b1);
      chk("lat_rip_t1", read_in_progress, 1);
      chk("lat_trig_t1", timetrig, 0);
      @(negedge clk);
      chk("lat_trig_t2", timetrig, 1);
      chk("lat_req_t2", conv_req, 0);
      @(negedge clk);
      chk("lat_trig_t3", timetrig, 0);
      chk("lat_req_t3", conv_req, 1);
      chk("lat_cfg_t3", conv_cfg, {1'b1, lowest(msk), 3'b101, 1'b1});
      wait_idle(2000, ok);
      mon_on = 1'b0;
      chk("lat_idle", ok, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"}, conv_req, 0);
      chk({tag, "_cfg"}, conv_cfg, 0);
      chk({tag, "_trig"}, timetrig, 0);
      chk({tag, "_cfgerr"}, cfg_error, 0);
      chk({tag, "_rip"}, read_in_progress, 0);
      chk({tag, "_ovr"}, overrun_count, 0);
   endtask

   vec_t vecs[$];

   initial begin
      bit ok;
      bit activity;
      vec_t rv;
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      sample_period = '0; n_reads = '0; active_channels = '0; range = '0; mode = 1'b0;

      vecs.push_back(mk(100, 1, 8'b1010_0101, 3'd3, 1'b0, 0, 2, 4, 1'b0));
      vecs.push_back(mk(60, 2, 8'b0001_0010, 3'd6, 1'b1, 7, 1, 4, 1'b0));
      vecs.push_back(mk(10, 3, 8'hFF, 3'd1, 1'b1, 0, 5, 24, 1'b1));
      vecs.push_back(mk(0, 3, 8'h01, 3'd7, 1'b0, 0, 0, 3, 1'b1));
      vecs.push_back(mk(30, 2, 8'h80, 3'd2, 1'b1, 2, 3, 2, 1'b0));

      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("rst");
      @(negedge clk);

      lat_test(8'h48);

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

      for (int i = 0; i < 6; i++) begin
         rv = mk($urandom_range(40, 0), $urandom_range(3, 1), 8'($urandom_range(255, 1)),
                 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                 $urandom_range(4, 0), $urandom_range(6, 0), 0, 1'b0);
         rv.exp_conv = $countones(rv.mask) * rv.nreads;
         run_vec(rv);
      end

      // zero channel mask
      active_channels = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("cfgerr_pulse", cfg_error, 1);
      chk("cfgerr_rip", read_in_progress, 0);
      @(negedge clk);
      chk("cfgerr_clear", cfg_error, 0);
      chk("cfgerr_stay_idle", read_in_progress, 0);

      // start and stop together
      active_channels = 8'hFF; sample_period = 5; n_reads = 1;
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      activity = 1'b0;
      repeat (6) begin
         if (read_in_progress || timetrig || conv_req) activity = 1'b1;
         @(negedge clk);
      end
      chk("start_stop_quiet", activity, 0);

      // stop while waiting for the next tick
      ack_dly = 0; done_dly = 0; resp_en = 1'b1; got_q.delete();
      done_cnt = 0;
      do_start(1000, 0, 8'h01, 3'd0, 1'b0);
      for (int unsigned i = 0; i < 100 && done_cnt == 0; i++) @(negedge clk);
      chk("wt_first_done", done_cnt, 1);
      repeat (4) @(negedge clk);
      chk("wt_still_busy", read_in_progress, 1);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      mon_on = 1'b0;
      chk("wt_stop_idle", read_in_progress, 0);
      repeat (3) @(negedge clk);

      // stop during the second of four conversions
      ack_dly = 0; done_dly = 6; got_q.delete();
      do_start(1000, 0, 8'h0F, 3'd4, 1'b1);
      for (int unsigned i = 0; i < 200 && got_q.size() < 2; i++) @(negedge clk);
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_idle(200, ok);
      mon_on = 1'b0;
      chk("sm_idle", ok, 1);
      chk("sm_idle_cycle", cyc, last_done_cyc + 1);
      repeat (10) @(negedge clk);
      chk("sm_no_more_req", got_q.size(), 2);
      if (got_q.size() >= 2) chk("sm_ch1_cfg", got_q[1], {1'b1, 3'd1, 3'd4, 1'b1});

      // reset while a continuous-mode request is pending
      resp_en = 1'b0;
      do_start(5, 0, 8'hFF, 3'd2, 1'b0);
      for (int unsigned i = 0; i < 20 && conv_req !== 1'b1; i++) @(negedge clk);
      chk("rmi_req_up", conv_req, 1);
      repeat (12) @(negedge clk);
      chk("rmi_overrun_seen", overrun_count != 16'd0, 1);
      mon_on = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_outputs("rmi");
      @(negedge clk);
      lat_test(8'h30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
